// File: rtl/nano_int_ctrl_n_if.sv
// ----------------------------------------------------------------------------
// nano_int_ctrl_n_if
// CPU I/O bus bundle for the Nano interrupt controller.
//   io_add  : I/O address driven by the CPU
//   io_din  : write data driven by the CPU
//   io_we   : write strobe driven by the CPU
//   io_dout : read data returned by the peripheral (combinational)
// Modports: master = CPU side, slave = peripheral side.
// ----------------------------------------------------------------------------
interface nano_int_ctrl_n_if;
    logic [7:0] io_add;
    logic [7:0] io_din;
    logic       io_we;
    logic [7:0] io_dout;

    modport master (
        output io_add,
        output io_din,
        output io_we,
        input  io_dout
    );

    modport slave (
        input  io_add,
        input  io_din,
        input  io_we,
        output io_dout
    );
endinterface

// File: rtl/nano_int_ctrl_n.sv
// ----------------------------------------------------------------------------
// nano_int_ctrl_n
// N-channel interrupt controller: input synchronisers, per-channel trigger
// mode, enable mask, pending register, software trigger and fixed-priority
// (lowest index wins) request generation.
// Ports:
//   clk_i     : system clock, all state on the rising edge
//   nrst_i    : synchronous active-low reset
//   eint_i    : asynchronous external interrupt inputs, one per channel
//   bus       : CPU I/O bus (slave modport), register window BASE_ADD..+5
//   int_o     : registered one-hot request of the winning channel
//   int_any_o : registered OR of all active channels
// Register offsets: 0 ENABLE, 1 MODE_LO, 2 MODE_HI, 3 PEND (W1C),
//                   4 VEC (RO), 5 SWTRIG (W1S, reads 0).
// ----------------------------------------------------------------------------
module nano_int_ctrl_n #(
    parameter int unsigned N_CH     = 3,
    parameter logic [7:0]  BASE_ADD = 8'hF0
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic [N_CH-1:0]   eint_i,
    nano_int_ctrl_n_if.slave  bus,
    output logic [N_CH-1:0]   int_o,
    output logic              int_any_o
);

    // Trigger decision for one channel from its synchronised level and the
    // level seen one cycle earlier.
    function automatic logic chan_event(input logic [1:0] mode,
                                        input logic       s2,
                                        input logic       p);
        logic ev;
        case (mode)
            2'b00:   ev = s2 & ~p;      // rising edge
            2'b01:   ev = ~s2 & p;      // falling edge
            2'b10:   ev = s2 ^ p;       // both edges
            2'b11:   ev = s2;           // level high
            default: ev = 1'b0;
        endcase
        return ev;
    endfunction

    logic [N_CH-1:0]   s1_q, s2_q, p_q;
    logic [N_CH-1:0]   en_q, en_d;
    logic [2*N_CH-1:0] mode_q, mode_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [1:0]        wu_q, wu_d;
    logic [N_CH-1:0]   int_q, int_d;
    logic              int_any_q, int_any_d;

    logic [7:0]        offset_s;
    logic              hit_s;
    logic              wr_en_s, wr_mlo_s, wr_mhi_s, wr_pend_s, wr_sw_s;
    logic              wu_done_s;
    logic [N_CH-1:0]   ev_s, clr_s, set_s, act_s, onehot_s;
    logic [2:0]        idx_s;
    logic              found_s;
    logic [7:0]        en_pad_s, pend_pad_s;
    logic [15:0]       mode_pad_s;
    logic [7:0]        rd_s;
    logic              unused_s;

    // Address decode; subtraction wraps so any BASE_ADD works.
    assign offset_s  = bus.io_add - BASE_ADD;
    assign hit_s     = (offset_s < 8'd6);
    assign wr_en_s   = bus.io_we & hit_s & (offset_s == 8'd0);
    assign wr_mlo_s  = bus.io_we & hit_s & (offset_s == 8'd1);
    assign wr_mhi_s  = bus.io_we & hit_s & (offset_s == 8'd2);
    assign wr_pend_s = bus.io_we & hit_s & (offset_s == 8'd3);
    assign wr_sw_s   = bus.io_we & hit_s & (offset_s == 8'd5);

    // Write-data bits above the channel count carry no state.
    assign unused_s  = ^{bus.io_din, wr_mhi_s, wr_mlo_s};

    // Warm-up counter saturates at 3; events are blocked until then so that
    // inputs already high at reset release do not look like edges.
    assign wu_done_s = (wu_q == 2'd3);
    assign wu_d      = wu_done_s ? 2'd3 : (wu_q + 2'd1);

    // Per-channel event detection from the synchronised input.
    always_comb begin
        ev_s = {N_CH{1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            if (wu_done_s) begin
                ev_s[k] = chan_event(mode_q[2*k +: 2], s2_q[k], p_q[k]);
            end else begin
                ev_s[k] = 1'b0;
            end
        end
    end

    // Register writes: ENABLE, MODE halves, and the pending set/clear merge
    // where a set in the same cycle overrides a write-1-to-clear.
    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        clr_s  = {N_CH{1'b0}};
        set_s  = ev_s;
        if (wr_en_s) begin
            en_d = bus.io_din[N_CH-1:0];
        end else begin
            en_d = en_q;
        end
        for (int k = 0; k < N_CH; k++) begin
            if ((k < 4) ? wr_mlo_s : wr_mhi_s) begin
                mode_d[2*k +: 2] = bus.io_din[(2*k) % 8 +: 2];
            end else begin
                mode_d[2*k +: 2] = mode_q[2*k +: 2];
            end
        end
        if (wr_pend_s) begin
            clr_s = bus.io_din[N_CH-1:0];
        end else begin
            clr_s = {N_CH{1'b0}};
        end
        if (wr_sw_s) begin
            set_s = ev_s | bus.io_din[N_CH-1:0];
        end else begin
            set_s = ev_s;
        end
        pend_d = (pend_q & ~clr_s) | set_s;
    end

    // Lowest-index active channel: one-hot request and its binary index.
    always_comb begin
        act_s    = pend_q & en_q;
        onehot_s = {N_CH{1'b0}};
        idx_s    = 3'd0;
        found_s  = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (act_s[k] && !found_s) begin
                onehot_s[k] = 1'b1;
                idx_s       = k[2:0];
                found_s     = 1'b1;
            end else begin
                found_s     = found_s;
            end
        end
        int_d     = onehot_s;
        int_any_d = |act_s;
    end

    // Zero-extend stored fields to full register width for reads.
    always_comb begin
        en_pad_s   = 8'h00;
        pend_pad_s = 8'h00;
        mode_pad_s = 16'h0000;
        en_pad_s[N_CH-1:0]     = en_q;
        pend_pad_s[N_CH-1:0]   = pend_q;
        mode_pad_s[2*N_CH-1:0] = mode_q;
    end

    // Combinational read mux; unmapped offsets and SWTRIG read zero.
    always_comb begin
        rd_s = 8'h00;
        if (hit_s) begin
            case (offset_s)
                8'd0:    rd_s = en_pad_s;
                8'd1:    rd_s = mode_pad_s[7:0];
                8'd2:    rd_s = mode_pad_s[15:8];
                8'd3:    rd_s = pend_pad_s;
                8'd4:    rd_s = {int_any_q, 4'b0000, idx_s};
                default: rd_s = 8'h00;
            endcase
        end else begin
            rd_s = 8'h00;
        end
    end

    assign bus.io_dout = rd_s;

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            s1_q      <= {N_CH{1'b0}};
            s2_q      <= {N_CH{1'b0}};
            p_q       <= {N_CH{1'b0}};
            en_q      <= {N_CH{1'b0}};
            mode_q    <= {(2*N_CH){1'b0}};
            pend_q    <= {N_CH{1'b0}};
            wu_q      <= 2'd0;
            int_q     <= {N_CH{1'b0}};
            int_any_q <= 1'b0;
        end else begin
            s1_q      <= eint_i;
            s2_q      <= s1_q;
            p_q       <= s2_q;
            en_q      <= en_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            wu_q      <= wu_d;
            int_q     <= int_d;
            int_any_q <= int_any_d;
        end
    end

    assign int_o     = int_q;
    assign int_any_o = int_any_q;

endmodule

// File: tb/tb_nano_int_ctrl_n.sv
// ----------------------------------------------------------------------------
// tb_nano_int_ctrl_n
// Directed bench for nano_int_ctrl_n. Three instances (3, 8 and 1 channels)
// share the bus stimulus. The 3-channel instance is tracked by a behavioural
// model built from the register rules and an input history; its request
// outputs are compared every cycle. Hand-computed literals pin key points.
// ----------------------------------------------------------------------------
module tb_nano_int_ctrl_n;

    localparam logic [7:0] BASE = 8'hF0;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] add, din;
    logic       we;
    logic [2:0] eint3;
    logic [7:0] eint8;
    logic [0:0] eint1;
    logic [2:0] int3;
    logic [7:0] int8;
    logic [0:0] int1;
    logic       any3, any8, any1;

    int checks = 0;
    int errors = 0;

    nano_int_ctrl_n_if bus3 ();
    nano_int_ctrl_n_if bus8 ();
    nano_int_ctrl_n_if bus1 ();

    assign bus3.io_add = add;  assign bus3.io_din = din;  assign bus3.io_we = we;
    assign bus8.io_add = add;  assign bus8.io_din = din;  assign bus8.io_we = we;
    assign bus1.io_add = add;  assign bus1.io_din = din;  assign bus1.io_we = we;

    nano_int_ctrl_n #(.N_CH(3), .BASE_ADD(BASE)) dut3 (
        .clk_i(clk), .nrst_i(nrst), .eint_i(eint3), .bus(bus3.slave),
        .int_o(int3), .int_any_o(any3));
    nano_int_ctrl_n #(.N_CH(8), .BASE_ADD(BASE)) dut8 (
        .clk_i(clk), .nrst_i(nrst), .eint_i(eint8), .bus(bus8.slave),
        .int_o(int8), .int_any_o(any8));
    nano_int_ctrl_n #(.N_CH(1), .BASE_ADD(BASE)) dut1 (
        .clk_i(clk), .nrst_i(nrst), .eint_i(eint1), .bus(bus1.slave),
        .int_o(int1), .int_any_o(any1));

    always #5 clk = ~clk;

    // ---------------- behavioural model of the 3-channel instance ----------
    logic [2:0] m_en, m_pend, m_int;
    logic       m_any;
    logic [1:0] m_mode [3];
    logic [2:0] hist [3];   // input level sampled 1, 2 and 3 edges ago
    int         m_edges;    // edges since reset release
    bit         m_valid = 1'b0;

    function automatic logic [2:0] lowest(input logic [2:0] v);
        for (int c = 0; c < 3; c++) if (v[c]) return 3'(c);
        return 3'd0;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        logic [7:0] off;
        off = a - BASE;
        case (off)
            8'd0:    return {5'b0, m_en};
            8'd1:    return {2'b0, m_mode[2], m_mode[1], m_mode[0]};
            8'd3:    return {5'b0, m_pend};
            8'd4:    return {m_any, 4'b0, lowest(m_pend & m_en)};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [2:0] act, ev, nxt_int;
        logic [7:0] off;
        logic       lvl, prev;
        if (!nrst) begin
            m_en = 3'b0; m_pend = 3'b0; m_int = 3'b0; m_any = 1'b0;
            for (int c = 0; c < 3; c++) begin m_mode[c] = 2'b00; hist[c] = 3'b0; end
            m_edges = 0;
            m_valid = 1'b1;
        end else begin
            act     = m_pend & m_en;
            nxt_int = (act == 3'b0) ? 3'b000 : (3'b001 << lowest(act));
            ev      = 3'b0;
            for (int c = 0; c < 3; c++) begin
                lvl  = hist[1][c];
                prev = hist[2][c];
                case (m_mode[c])
                    2'b00:   ev[c] = lvl && !prev;
                    2'b01:   ev[c] = !lvl && prev;
                    2'b10:   ev[c] = lvl != prev;
                    default: ev[c] = lvl;
                endcase
                if (m_edges < 3) ev[c] = 1'b0;
            end
            off = add - BASE;
            if (we && off == 8'd3) m_pend = m_pend & ~din[2:0];
            m_pend = m_pend | ev;
            if (we && off == 8'd5) m_pend = m_pend | din[2:0];
            if (we && off == 8'd0) m_en = din[2:0];
            if (we && off == 8'd1)
                for (int c = 0; c < 3; c++) m_mode[c] = din[2*c +: 2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = eint3;
            m_edges++;
            m_int = nxt_int;
            m_any = (act != 3'b0);
        end
    end

    // ---------------- checking -------------------------------------------
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of the request outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("int3_model", {5'b0, int3}, {5'b0, m_int});
            chk("any3_model", {7'b0, any3}, {7'b0, m_any});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] d);
        add = BASE + off; din = d; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; din = 8'h00;
    endtask

    // Read one register of one instance and compare with a literal; reads of
    // the 3-channel instance are also compared with the model.
    task automatic rd(input int which, input logic [7:0] off, input logic [7:0] exp,
                      input string nm);
        logic [7:0] v;
        add = BASE + off;
        #1;
        v = (which == 3) ? bus3.io_dout : (which == 8) ? bus8.io_dout : bus1.io_dout;
        chk(nm, v, exp);
        if (which == 3) chk({nm, "_model"}, v, m_read(add));
    endtask

    initial begin
        nrst = 1'b0; add = 8'h00; din = 8'h00; we = 1'b0;
        eint3 = 3'b111; eint8 = 8'h00; eint1 = 1'b0;

        // Reset and warm-up with inputs held high
        tick(3);
        for (int o = 0; o < 6; o++) rd(3, 8'(o), 8'h00, "reset_read3");
        rd(8, 8'd0, 8'h00, "reset_en8");
        chk("reset_int3", {5'b0, int3}, 8'h00);
        nrst = 1'b1;
        wr(8'd1, 8'h00);
        wr(8'd0, 8'h07);
        tick(4);
        rd(3, 8'd3, 8'h00, "warmup_pend");
        chk("warmup_int", {5'b0, int3}, 8'h00);

        // Rising detection on ch1
        eint3 = 3'b000;
        tick(4);
        wr(8'd0, 8'h02);
        eint3 = 3'b010;
        tick(3);
        rd(3, 8'd3, 8'h02, "rise_pend_k2");
        chk("rise_int_k2", {5'b0, int3}, 8'h00);
        tick(1);
        chk("rise_int_k3", {5'b0, int3}, 8'h02);
        rd(3, 8'd4, 8'h81, "rise_vec");
        wr(8'd3, 8'h02);
        tick(1);
        chk("rise_clr_int", {5'b0, int3}, 8'h00);

        // Falling mode on ch0
        wr(8'd1, 8'h01);
        eint3 = 3'b011;
        tick(4);
        rd(3, 8'd3, 8'h00, "fall_rise_none");
        eint3 = 3'b010;
        tick(3);
        rd(3, 8'd3, 8'h01, "fall_pend");
        wr(8'd3, 8'h01);

        // Both-edges mode on ch2
        wr(8'd1, 8'h20);
        eint3 = 3'b110;
        tick(3);
        rd(3, 8'd3, 8'h04, "both_rise");
        wr(8'd3, 8'h04);
        tick(1);
        rd(3, 8'd3, 8'h00, "both_cleared");
        eint3 = 3'b010;
        tick(3);
        rd(3, 8'd3, 8'h04, "both_fall");
        wr(8'd3, 8'h04);

        // Level mode on ch1 with simultaneous set/clear
        wr(8'd1, 8'h0C);
        tick(2);
        for (int r = 0; r < 3; r++) begin
            wr(8'd3, 8'h02);
            rd(3, 8'd3, 8'h02, "level_set_wins");
        end
        eint3 = 3'b000;
        tick(3);
        wr(8'd3, 8'h02);
        rd(3, 8'd3, 8'h00, "level_cleared");
        wr(8'd1, 8'h00);

        // Priority and masking
        wr(8'd0, 8'h06);
        wr(8'd5, 8'h06);
        tick(1);
        chk("prio_int_ch1", {5'b0, int3}, 8'h02);
        rd(3, 8'd4, 8'h81, "prio_vec1");
        wr(8'd0, 8'h04);
        tick(1);
        chk("mask_int_ch2", {5'b0, int3}, 8'h04);
        rd(3, 8'd4, 8'h82, "mask_vec2");
        wr(8'd3, 8'h04);
        tick(1);
        chk("mask_clr_int", {5'b0, int3}, 8'h00);
        rd(3, 8'd3, 8'h02, "mask_pend_left");
        rd(3, 8'd5, 8'h00, "swtrig_reads0");

        // Unmapped access and channel-count masking
        wr(8'd3, 8'hFF);
        wr(8'd0, 8'hFF);
        rd(1, 8'd0, 8'h01, "n1_enable");
        rd(3, 8'd0, 8'h07, "n3_enable");
        rd(8, 8'd0, 8'hFF, "n8_enable");
        rd(3, 8'd6, 8'h00, "unmapped3");
        rd(8, 8'd6, 8'h00, "unmapped8");
        rd(1, 8'd6, 8'h00, "unmapped1");
        wr(8'd6, 8'hFF);
        rd(8, 8'd0, 8'hFF, "unmapped_wr8");

        // N_CH=8: simultaneous ch7/ch3 events; N_CH=1 rising
        eint8 = 8'h88;
        eint1 = 1'b1;
        tick(4);
        chk("n8_int", int8, 8'h08);
        rd(8, 8'd4, 8'h83, "n8_vec");
        rd(8, 8'd3, 8'h88, "n8_pend");
        chk("n1_int", {7'b0, int1}, 8'h01);
        rd(1, 8'd4, 8'h80, "n1_vec");
        wr(8'd2, 8'hFF);
        rd(3, 8'd2, 8'h00, "n3_modehi");
        rd(8, 8'd2, 8'hFF, "n8_modehi");
        wr(8'd4, 8'h00);
        rd(8, 8'd4, 8'h83, "n8_vec_ro");

        // Reset mid-operation discards pending requests
        wr(8'd5, 8'h07);
        tick(1);
        chk("pre_reset_int", {5'b0, int3}, 8'h01);
        nrst = 1'b0;
        tick(1);
        rd(3, 8'd3, 8'h00, "midrst_pend3");
        rd(8, 8'd3, 8'h00, "midrst_pend8");
        chk("midrst_int3", {5'b0, int3}, 8'h00);
        chk("midrst_int8", int8, 8'h00);
        nrst = 1'b1;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nano_int_ctrl_n.md
# nano_int_ctrl_n

Parametrised N-channel interrupt controller for the Nano microcontroller system. It replaces the fixed three-channel arrangement of separate edge detectors plus interrupt controller with a single block. The block integrates input synchronisation, a per-channel trigger mode, an enable mask, a pending register, software triggering and fixed-priority request generation. It sits on the CPU I/O bus and drives the CPU interrupt request lines.

## Interface
- `N_CH`, default 3: number of interrupt channels, legal range 1..8.
- `BASE_ADD`, default 8'hF0: I/O address of register offset 0; the block decodes `BASE_ADD`..`BASE_ADD`+5.
- `CLK` input, 1 bit: single system clock; all state updates on the rising edge.
- `NRST` input, 1 bit: reset, synchronous and active-low.
- `EINT` input, `N_CH` bits: asynchronous external interrupt inputs.
- `IO_ADD` input, 8 bits: CPU I/O address.
- `IO_DIN` input, 8 bits: CPU write data.
- `IO_WE` input, 1 bit: write strobe; a write occurs at the rising edge where `IO_WE`=1 and the address is decoded.
- `IO_DOUT` output, 8 bits: read data, combinational from `IO_ADD` and the register state.
- `INT` output, `N_CH` bits: registered one-hot request for the highest-priority active channel.
- `INT_ANY` output, 1 bit: registered OR of `INT`.

## Operation
- **Register map** (offset from `BASE_ADD`):
  - 0 ENABLE: read/write, 1 bit per channel.
  - 1 MODE_LO: read/write, 2 bits per channel for ch0..3, with ch k at bits [2k+1:2k].
  - 2 MODE_HI: read/write, same layout for ch4..7.
  - 3 PEND: read = pending bits; write = write-1-to-clear.
  - 4 VEC: read-only, returns {`INT_ANY`, 4'b0, idx[2:0]}.
  - 5 SWTRIG: write-1-to-set pending; reads 0.
- **Register bit rules:**
  - Bits for channels ≥ `N_CH` are not stored and read 0.
  - Unmapped addresses read 8'h00; writes to them are ignored.
  - Writes to VEC are ignored.
- **MODE encoding:** 00 rising edge, 01 falling edge, 10 both edges, 11 level-high.
- **Input path per channel:** two-flop synchroniser (s1→s2), then a previous-value register p loaded from s2 every cycle.
  - Rising event: s2 & ~p. Falling event: ~s2 & p. Level event: s2.
- **Pending:** set on an event regardless of ENABLE. It is cleared only by a PEND write-1, or by reset.
  - If set and clear hit the same bit in the same cycle, set wins.
  - In level mode, pending therefore cannot be cleared while s2=1.
- **Active** = PEND & ENABLE.
- **Priority:** the lowest index wins. idx = index of the lowest set active bit; idx=0 when none is set.
- **`INT`:** registered one-hot of the winning channel, or all zero. `INT_ANY` is registered |active.
- **Warm-up:** a 2-bit counter counts 0→3 after reset release and saturates at 3. Edge and level events are suppressed while it is below 3. This prevents inputs already high at reset release from registering a spurious edge. SWTRIG works during warm-up.
- **Reset (`NRST`=0 at a rising edge):** all of the following go to 0:
  - s1, s2, p
  - ENABLE, MODE_LO, MODE_HI, PEND
  - warm-up counter
  - `INT`, `INT_ANY`

  With that state, `IO_DOUT` reads 0 at every address. Reset mid-operation discards all pending requests.

## Timing
- **External event latency:** let edge k be the first rising edge at which s1 captures the new `EINT` level.
  - s2 updates at k+1.
  - PEND sets at k+2.
  - `INT`/`INT_ANY` assert at k+3, if the channel is enabled and wins priority.
- **Input pulses:** a pulse must be stable for ≥2 clocks to be guaranteed detection. Both-edges mode on a 2-cycle pulse produces two events; both collapse into a single pending bit.
- **Register writes** take effect at the write edge.
  - SWTRIG or ENABLE write at edge w: `INT` changes at w+1.
  - PEND clear at edge w: `INT` deasserts at w+1, unless a new event sets the bit at w.
- **Reads** are combinational in the same cycle and reflect register values after the most recent edge.
- **Priority:** a higher-priority channel becoming active while a lower one is asserted moves `INT` to the new channel on the next edge; the lower channel stays pending.

## Test plan
- **Reset and warm-up:** hold `EINT`=3'b111 through reset, with MODE rising and ENABLE=3'b111 written during warm-up → PEND stays 0 and `INT`=0.
- **Rising detection:** ENABLE=3'b010, MODE_LO=0, drive a rising edge on `EINT[1]` → PEND=8'h02 at k+2; `INT`=3'b010 and VEC=8'h81 at k+3. Write PEND=8'h02 → `INT`=0 the next cycle.
- **Falling and both-edges modes:**
  - Ch0 falling: a 0→1 transition gives no event; the following 1→0 transition sets PEND bit0.
  - Ch2 both-edges: each transition sets bit2 after it has been cleared in between.
- **Level mode with simultaneous set/clear:** ch1 in level mode, `EINT[1]` held high, repeated PEND writes of 8'h02 → bit stays 1 (set wins). After `EINT[1]` drops, a clear write gives PEND=0.
- **Priority and masking:** SWTRIG=8'h06 with ENABLE=3'b110 → `INT`=3'b010. Then ENABLE=3'b100 → `INT`=3'b100 the next cycle. Then PEND write 8'h04 → `INT`=0; PEND still reads 8'h02.
- **Unmapped access and `N_CH`:** instantiate with `N_CH`=8 and with `N_CH`=1.
  - Read at `BASE_ADD`+6 → 8'h00.
  - With `N_CH`=1, ENABLE write 8'hFF reads back 8'h01.
  - With `N_CH`=8, a simultaneous channel-7 and channel-3 event gives idx=3.
